// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction ROM and queues {word, pc} for decode.
// Define FETCH_PERF_EN to add the perf_stall_cycles / perf_fetched counters.
module imem_fetch_ctrl #(
  parameter int N          = 32,
  parameter int INS        = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] imem_pc,
  input  logic [N-1:0] imem_instruction,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] instr_pc,
  output logic         busy,
  output logic         done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_fetched
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [N-1:0]  INS_N   = N'(INS);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  pc_reg, pc_next, pc_after;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  fifo_instr_reg [FIFO_DEPTH];
  logic [N-1:0]  fifo_pc_reg    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_we;
  logic          pop, push, flush, pc_in_range;

  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready;
  assign pc_in_range = (pc_reg < INS_N);
  assign imem_pc     = pc_reg;
  assign instr_out   = fifo_instr_reg[rd_ptr_reg];
  assign instr_pc    = fifo_pc_reg[rd_ptr_reg];
  assign busy        = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
  assign done        = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pc_after   = pc_reg;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          flush      = 1'b1;
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end else begin
          // A full FIFO may still accept a word when decode pops the head this cycle.
          push     = pc_in_range && ((count_reg < DEPTH_C) || pop);
          pc_after = push ? pc_reg + N'(1) : pc_reg;
          pc_next  = pc_after;
          if (pc_after >= INS_N) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          pc_next    = redirect_pc;
          state_next = S_FETCH;
        end else if ((count_reg == '0) || ((count_reg == CW'(1)) && pop)) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
    assign entry_we[gi] = push && (wr_ptr_reg == AW'(gi));
  end

  // Entries are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (!rst_n) begin
        fifo_instr_reg[i] <= '0;
        fifo_pc_reg[i]    <= '0;
      end else if (entry_we[i]) begin
        fifo_instr_reg[i] <= imem_instruction;
        fifo_pc_reg[i]    <= pc_reg;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic        perf_clear, stall_now;
  logic [31:0] stall_cnt_reg, fetched_cnt_reg;

  assign perf_clear = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  // In FETCH without redirect, an in-range PC that does not push means a full FIFO with no pop.
  assign stall_now  = (state_reg == S_FETCH) && !redirect_valid && pc_in_range && !push;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clear) begin
      stall_cnt_reg   <= '0;
      fetched_cnt_reg <= '0;
    end else begin
      stall_cnt_reg   <= stall_cnt_reg + 32'(stall_now);
      fetched_cnt_reg <= fetched_cnt_reg + 32'(push);
    end
  end

  assign perf_stall_cycles = stall_cnt_reg;
  assign perf_fetched      = fetched_cnt_reg;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the fetch rules. Perf counters are checked when FETCH_PERF_EN is defined.
module tb_imem_fetch_ctrl;

  localparam int N     = 32;
  localparam int INS   = 10;
  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_FETCH = 1, M_DRAIN = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [N-1:0] redirect_pc = '0;
  logic         instr_ready = 1'b0;
  logic [N-1:0] imem_pc, imem_instruction, instr_out, instr_pc;
  logic         instr_valid, busy, done;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_stall_cycles, perf_fetched;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop_cyc = 0;

  // reference model
  int          m_mode = M_IDLE;
  int unsigned m_pc = 0;
  int unsigned m_qpc[$];
  logic [31:0] m_qins[$];
  int unsigned m_stall = 0;
  int unsigned m_fetched = 0;

  // observed accepted beats
  int unsigned seen_pc[$];
  logic [31:0] seen_ins[$];
  int          seen_cyc[$];

  imem_fetch_ctrl #(.N(N), .INS(INS), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .busy             (busy),
    .done             (done)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_fetched     (perf_fetched)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a < INS) ? a + 32'd100 : 32'hDEADBEEF;
  endfunction

  assign imem_instruction = rom(imem_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pop, push;
    pop  = instr_ready && (m_qpc.size() != 0);
    push = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 0; m_qpc.delete(); m_qins.delete();
      m_stall = 0; m_fetched = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (start) begin
          m_mode = M_FETCH; m_pc = 0; m_qpc.delete(); m_qins.delete();
          m_stall = 0; m_fetched = 0;
        end
      end
      default: begin
        if (redirect_valid) begin
          m_mode = M_FETCH; m_pc = redirect_pc; m_qpc.delete(); m_qins.delete();
        end else begin
          if (m_mode == M_FETCH && m_pc < INS)
            push = (m_qpc.size() < DEPTH) || pop;
          if (m_mode == M_FETCH && m_pc < INS && !push) m_stall++;
          if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qins.pop_front());
          end
          if (push) begin
            m_qins.push_back(rom(m_pc));
            m_qpc.push_back(m_pc);
            m_pc++;
            m_fetched++;
          end
          if (m_mode == M_FETCH && m_pc >= INS) m_mode = M_DRAIN;
          else if (m_mode == M_DRAIN && m_qpc.size() == 0) m_mode = M_DONE;
        end
      end
    endcase
  endtask

  // Compare outputs against the model, log the beat, then advance one clock.
  task automatic tick();
    chk("instr_valid", 32'(instr_valid), 32'(m_qpc.size() != 0));
    if (m_qpc.size() != 0) begin
      chk("instr_out", instr_out, m_qins[0]);
      chk("instr_pc", instr_pc, m_qpc[0]);
    end
    chk("imem_pc", imem_pc, m_pc);
    chk("busy", 32'(busy), 32'(m_mode == M_FETCH || m_mode == M_DRAIN));
    chk("done", 32'(done), 32'(m_mode == M_DONE));
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cycles, m_stall);
    chk("perf_fetched", perf_fetched, m_fetched);
`endif
    if (rst_n && instr_valid && instr_ready) begin
      seen_pc.push_back(instr_pc);
      seen_ins.push_back(instr_out);
      seen_cyc.push_back(cyc);
      last_pop_cyc = cyc;
      $display("[TB] cycle %0d beat pc=%0d instr=%0d", cyc, instr_pc, instr_out);
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_seen();
    seen_pc.delete();
    seen_ins.delete();
    seen_cyc.delete();
  endtask

  task automatic run_to_done(input string tag, input int limit);
    int b;
    b = 0;
    while (!done && b < limit) begin
      tick();
      b++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int mark;

    // Reset state
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Streaming with decode always ready
    clear_seen();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(instr_valid), 32'd1);
    chk("lat_c2_pc", instr_pc, 32'd0);
    run_to_done("stream_done", 40);
    chk("stream_done_lat", 32'(cyc - last_pop_cyc), 32'd1);
    chk("stream_busy", 32'(busy), 32'd0);
    chk("stream_count", 32'(seen_pc.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < seen_pc.size()) begin
        chk("stream_pc", seen_pc[i], 32'(i));
        chk("stream_ins", seen_ins[i], 32'(i + 100));
      end
    end
    if (seen_cyc.size() == 10) chk("stream_back2back", 32'(seen_cyc[9] - seen_cyc[0]), 32'd9);

    // Backpressure: decode stalls, FIFO fills, PC holds
    clear_seen();
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_imem_pc", imem_pc, 32'd2);
    chk("bp_out", instr_out, 32'd100);
    instr_ready = 1'b1;
    run_to_done("bp_done", 40);
    chk("bp_count", 32'(seen_pc.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < seen_ins.size()) chk("bp_ins", seen_ins[i], 32'(i + 100));
    end
`ifdef FETCH_PERF_EN
    chk("bp_perf_stall", perf_stall_cycles, 32'd4);
    chk("bp_perf_fetched", perf_fetched, 32'd10);
`endif

    // Redirect to pc 7 while pc 3 is at the head with pc 4 queued
    clear_seen();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    while (!(instr_valid && instr_pc == 3) && b < 20) begin
      tick();
      b++;
    end
    chk("rd_head3", instr_pc, 32'd3);
    instr_ready = 1'b0;
    tick();
    chk("rd_queued_imem_pc", imem_pc, 32'd5);
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mark = seen_pc.size();
    run_to_done("rd_done", 20);
    chk("rd_count", 32'(seen_pc.size() - mark), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (mark + i < seen_pc.size()) chk("rd_pc", seen_pc[mark + i], 32'(7 + i));
    end

    // Out-of-range redirect, then restart
    clear_seen();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd12;
    tick();
    redirect_valid = 1'b0;
    chk("oor_valid", 32'(instr_valid), 32'd0);
    run_to_done("oor_done", 2);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("oor_restart_pc", imem_pc, 32'd0);
    chk("oor_restart_busy", 32'(busy), 32'd1);
    mark = seen_pc.size();
    run_to_done("oor_restart_done", 40);
    if (mark < seen_pc.size()) chk("oor_restart_first", seen_pc[mark], 32'd0);
    chk("oor_restart_count", 32'(seen_pc.size() - mark), 32'd10);

    // Reset in the middle of a run with two entries queued
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mr_full_imem_pc", imem_pc, 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_imem_pc", imem_pc, 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1;
      redirect_pc = $urandom_range(0, 9);
      tick();
      chk("mr_stay_idle", 32'(busy), 32'd0);
    end
    redirect_valid = 1'b0;

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      start          = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom_range(0, 12);
      rst_n          = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
